// File: rtl/dense_pkg.sv
// Shared widths and index helpers for the dense/conv streaming stages.
// Used by dense_stream_mac (optional DENSE_RELU_EN clamp lives in dense_mac_lane).
package dense_pkg;

  localparam int DENSE_DATA_W = 8;
  localparam int DENSE_ACC_W  = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Low bit of lane `lane` in a bus of `width`-bit lanes packed from bit 0 upward.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One signed MAC lane: product, bias-seeded accumulator and result register.
// With DENSE_RELU_EN defined the result is clamped at zero on the final beat.
module dense_mac_lane
  import dense_pkg::*;
#(
  parameter int DATA_W = DENSE_DATA_W,
  parameter int ACC_W  = DENSE_ACC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     first,
  input  logic                     last,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [ACC_W-1:0]  bias,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    nxt;
  logic signed [ACC_W-1:0]    acc_p1;
  logic signed [ACC_W-1:0]    sum_p1;

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef DENSE_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign prod     = (2*DATA_W)'(pixel) * (2*DATA_W)'(weight);
  assign prod_ext = ACC_W'(prod);
  assign base     = first ? bias : acc_p1;
  assign nxt      = base + prod_ext;

  // Stage p1: accumulate; the final beat moves the sum out and clears the accumulator
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_p1 <= '0;
      sum_p1 <= '0;
    end else if (en) begin
      if (last) begin
        sum_p1 <= relu(nxt);
        acc_p1 <= '0;
      end else begin
        acc_p1 <= nxt;
      end
    end
  end

  assign sum = sum_p1;

endmodule

// File: rtl/dense_stream_mac.sv
// Streaming fully connected layer: NUM_TREES parallel MAC lanes over IN_LEN-pixel vectors.
// Define DENSE_RELU_EN to clamp negative lane sums to zero.
module dense_stream_mac
  import dense_pkg::*;
#(
  parameter int NUM_TREES = 4,
  parameter int DATA_W    = DENSE_DATA_W,
  parameter int ACC_W     = DENSE_ACC_W,
  parameter int IN_LEN    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      pixel_in,
  input  logic [DATA_W*NUM_TREES-1:0]   kernel_in,
  input  logic [ACC_W*NUM_TREES-1:0]    bias_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W*NUM_TREES-1:0]    pixel_out,
  output logic                          busy
);

  localparam int              CNT_W    = (clog2(IN_LEN) < 1) ? 1 : clog2(IN_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_LEN - 1);

  logic [CNT_W-1:0] cnt_p1;
  logic             vld_p1;
  logic             first;
  logic             last;
  logic             fire;

  assign first = (cnt_p1 == '0);
  assign last  = (cnt_p1 == LAST_CNT);

  // Only the final beat can stall: it would overwrite a result still waiting for out_ready.
  assign in_ready = !last || !vld_p1 || out_ready;
  assign fire     = in_valid && in_ready;

  // Stage p1: beat counter and result-valid flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (fire) cnt_p1 <= last ? '0 : cnt_p1 + 1'b1;
      if (fire && last) vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign busy      = (cnt_p1 != '0);

  for (genvar i = 0; i < NUM_TREES; i++) begin : g_lane
    dense_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clock  (clock),
      .reset  (reset),
      .en     (fire),
      .first  (first),
      .last   (last),
      .pixel  (pixel_in),
      .weight (kernel_in[lane_lo(i, DATA_W) +: DATA_W]),
      .bias   (bias_in[lane_lo(i, ACC_W) +: ACC_W]),
      .sum    (pixel_out[lane_lo(i, ACC_W) +: ACC_W])
    );
  end

endmodule

// File: tb/tb_dense_stream_mac.sv
// Directed bench for dense_stream_mac: a 4-beat/32-bit instance and a 1-beat/16-bit instance.
// Expected lane values follow the DENSE_RELU_EN build setting.
module tb_dense_stream_mac;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic signed [7:0]  a_pixel;
  logic [15:0]        a_kernel;
  logic [63:0]        a_bias, a_pixel_out;

  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic signed [7:0]  b_pixel;
  logic [15:0]        b_kernel;
  logic [31:0]        b_bias, b_pixel_out;

  dense_stream_mac #(.NUM_TREES(2), .DATA_W(8), .ACC_W(32), .IN_LEN(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .pixel_in(a_pixel), .kernel_in(a_kernel), .bias_in(a_bias), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .pixel_out(a_pixel_out), .busy(a_busy));

  dense_stream_mac #(.NUM_TREES(2), .DATA_W(8), .ACC_W(16), .IN_LEN(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .pixel_in(b_pixel), .kernel_in(b_kernel), .bias_in(b_bias), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .pixel_out(b_pixel_out), .busy(b_busy));

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // reference model state for the random phase
  int                m_acc [2];
  int                m_out [2];
  int                m_cnt;
  bit                m_ov, m_rdy, m_fire, m_last, m_consume;
  int                prod, base, produced, cyc;
  logic signed [7:0] kw;

  function automatic int r(input int v);
`ifdef DENSE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] pk2(input int l1, input int l0);
    return {32'(l1), 32'(l0)};
  endfunction

  function automatic logic [63:0] pk16(input int l1, input int l0);
    return {32'd0, 16'(l1), 16'(l0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_beat(input int pix, input int k1, input int k0, input int b1, input int b0);
    a_in_valid = 1'b1;
    a_pixel    = 8'(pix);
    a_kernel   = {8'(k1), 8'(k0)};
    a_bias     = {32'(b1), 32'(b0)};
    @(negedge clock);
    a_in_valid = 1'b0;
  endtask

  task automatic b_beat(input int pix, input int k1, input int k0, input int b1, input int b0);
    b_in_valid = 1'b1;
    b_pixel    = 8'(pix);
    b_kernel   = {8'(k1), 8'(k0)};
    b_bias     = {16'(b1), 16'(b0)};
    @(negedge clock);
    b_in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_pixel = '0; a_kernel = '0; a_bias = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_pixel = '0; b_kernel = '0; b_bias = '0;
    repeat (2) @(negedge clock);
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_out", a_pixel_out, 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_ready", 64'(a_in_ready), 64'd1);
    reset = 1'b1;
    @(negedge clock);

    // basic 4-beat vector, bias only taken on the first beat
    a_out_ready = 1'b1;
    a_beat(1, 2, 1, -5, 10);
    check("t1_busy", 64'(a_busy), 64'd1);
    check("t1_novalid", 64'(a_out_valid), 64'd0);
    a_beat(2, 2, 1, 999, 999);
    a_beat(3, 2, 1, 999, 999);
    a_beat(4, 2, 1, 999, 999);
    check("t1_valid", 64'(a_out_valid), 64'd1);
    check("t1_sum", a_pixel_out, pk2(r(15), r(20)));
    check("t1_idle", 64'(a_busy), 64'd0);
    @(negedge clock);
    check("t1_pulse", 64'(a_out_valid), 64'd0);
    check("t1_hold", a_pixel_out, pk2(r(15), r(20)));

    // backpressure: two vectors back-to-back with out_ready low
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) a_beat(1, 1, 1, 0, 0);
    check("t3_valid_a", 64'(a_out_valid), 64'd1);
    check("t3_sum_a", a_pixel_out, pk2(4, 4));
    a_beat(2, 3, 1, 0, 100);
    check("t3_ready_mid", 64'(a_in_ready), 64'd1);
    a_beat(2, 3, 1, 0, 0);
    a_beat(2, 3, 1, 0, 0);
    check("t3_ready_last", 64'(a_in_ready), 64'd0);
    check("t3_stable", a_pixel_out, pk2(4, 4));
    a_in_valid = 1'b1; a_pixel = 8'sd2; a_kernel = {8'd3, 8'd1};
    @(negedge clock);
    check("t3_stall", a_pixel_out, pk2(4, 4));
    check("t3_stall_busy", 64'(a_busy), 64'd1);
    a_out_ready = 1'b1;
    #1;
    check("t3_ready_go", 64'(a_in_ready), 64'd1);
    @(negedge clock);
    a_in_valid = 1'b0;
    check("t3_valid_b", 64'(a_out_valid), 64'd1);
    check("t3_sum_b", a_pixel_out, pk2(r(24), r(108)));
    check("t3_idle", 64'(a_busy), 64'd0);
    @(negedge clock);
    check("t3_drain", 64'(a_out_valid), 64'd0);

    // reset mid-vector with an unconsumed result pending
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) a_beat(5, 1, 1, 0, 0);
    a_beat(50, 1, 1, 0, 0);
    a_beat(50, 1, 1, 0, 0);
    check("t4_busy_pre", 64'(a_busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("t4_busy", 64'(a_busy), 64'd0);
    check("t4_valid", 64'(a_out_valid), 64'd0);
    check("t4_out", a_pixel_out, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    a_out_ready = 1'b1;
    a_beat(1, 2, 1, -5, 10);
    a_beat(2, 2, 1, 0, 0);
    a_beat(3, 2, 1, 0, 0);
    a_beat(4, 2, 1, 0, 0);
    check("t4_sum", a_pixel_out, pk2(r(15), r(20)));
    @(negedge clock);
    check("t4_drain", 64'(a_out_valid), 64'd0);

    // single-beat vectors on the 16-bit instance: signed extremes and wrap
    b_out_ready = 1'b1;
    b_beat(-128, 1, -128, 0, 0);
    check("t2_valid", 64'(b_out_valid), 64'd1);
    check("t2_min", 64'(b_pixel_out), pk16(r(-128), r(16384)));
    b_beat(-3, 5, 5, 0, 0);
    check("t2_valid_b2b", 64'(b_out_valid), 64'd1);
    check("t2_neg", 64'(b_pixel_out), pk16(r(-15), r(-15)));
    b_beat(1, 0, 1, 32767, 32767);
    check("t5_wrap", 64'(b_pixel_out), pk16(r(32767), r(-32768)));
    b_out_ready = 1'b0;
    #1;
    check("t5_ready_stall", 64'(b_in_ready), 64'd0);
    b_in_valid = 1'b1; b_pixel = 8'sd7; b_kernel = {8'd1, 8'd1}; b_bias = '0;
    @(negedge clock);
    check("t5_hold", 64'(b_pixel_out), pk16(r(32767), r(-32768)));
    check("t5_hold_valid", 64'(b_out_valid), 64'd1);
    b_out_ready = 1'b1;
    @(negedge clock);
    b_in_valid = 1'b0;
    check("t5_next", 64'(b_pixel_out), pk16(7, 7));
    @(negedge clock);
    check("t5_drain", 64'(b_out_valid), 64'd0);

    // random valid/ready against a reference model on the 4-beat instance
    m_cnt = 0; m_ov = 1'b0; produced = 0; cyc = 0;
    m_acc[0] = 0; m_acc[1] = 0; m_out[0] = 0; m_out[1] = 0;
    while (produced < 40 && cyc < 4000) begin
      check("rnd_valid", 64'(a_out_valid), 64'(m_ov));
      if (m_ov) check("rnd_sum", a_pixel_out, pk2(m_out[1], m_out[0]));
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_pixel     = 8'($urandom);
      a_kernel    = 16'($urandom);
      a_bias      = {32'(int'($urandom_range(0, 2000)) - 1000),
                     32'(int'($urandom_range(0, 2000)) - 1000)};
      #1;
      m_rdy = (m_cnt != 3) || !m_ov || a_out_ready;
      check("rnd_ready", 64'(a_in_ready), 64'(m_rdy));
      m_consume = m_ov && a_out_ready;
      m_fire    = a_in_valid && m_rdy;
      m_last    = (m_cnt == 3);
      if (m_fire) begin
        for (int i = 0; i < 2; i++) begin
          kw   = a_kernel[i*8 +: 8];
          prod = int'(a_pixel) * int'(kw);
          base = (m_cnt == 0) ? int'($signed(a_bias[i*32 +: 32])) : m_acc[i];
          if (m_last) begin
            m_out[i] = r(base + prod);
            m_acc[i] = 0;
          end else begin
            m_acc[i] = base + prod;
          end
        end
        m_cnt = m_last ? 0 : m_cnt + 1;
      end
      if (m_fire && m_last) begin
        m_ov = 1'b1;
        produced++;
      end else if (m_consume) begin
        m_ov = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    check("rnd_count", 64'(produced >= 40), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
